tpu_cmd_frontend: RTL and testbench

//  Host-facing command front-end for the TPU core.
//  - Host programs operand fields through a simple 32-bit register port.
//  - A doorbell write snapshots the fields into one packed 64-bit command.
//  - The command is pushed to the control unit over cmd_valid/cmd_data/cmd_ready.
//  - Tracks outstanding commands through done_irq and raises a maskable host interrupt.

---
 rtl/tpu_pkg.sv | 34 +++
 rtl/tpu_cmd_frontend.sv | 134 +++++++++++++
 tb/tb_tpu_cmd_frontend.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// tpu_pkg: command format, register map and status bit positions shared by the TPU front-end and control unit
package tpu_pkg;
  localparam int CMD_AW = 10;
  localparam int CMD_W  = 64;
  localparam logic [3:0] REG_DIMS     = 4'h0;
  localparam logic [3:0] REG_ADDR_AB  = 4'h1;
  localparam logic [3:0] REG_ADDR_CD  = 4'h2;
  localparam logic [3:0] REG_DOORBELL = 4'h3;
  localparam logic [3:0] REG_STATUS   = 4'h4;
  localparam logic [3:0] REG_CTRL     = 4'h5;
  localparam int ST_CMD_VALID = 0;
  localparam int ST_CORE_BUSY = 1;
  localparam int ST_IRQ_PEND  = 2;
  localparam int ST_ERR_OVF   = 3;
  localparam int ST_ERR_DIM   = 4;
  localparam int ST_ERR_SPUR  = 5;
  localparam int ST_OUTST_LSB = 8;
  localparam int ST_COMPL_LSB = 16;
  typedef struct packed {
    logic [CMD_AW-1:0] addr_d;
    logic [CMD_AW-1:0] addr_c;
    logic [CMD_AW-1:0] addr_b;
    logic [CMD_AW-1:0] addr_a;
    logic [7:0]        len_n;
    logic [7:0]        len_k;
    logic [7:0]        len_m;
  } command_t;
  function automatic logic [CMD_W-1:0] pack_cmd(input command_t c);
    return {c.addr_d, c.addr_c, c.addr_b, c.addr_a, c.len_n, c.len_k, c.len_m};
  endfunction
  function automatic logic len_ok(input logic [7:0] len, input logic [7:0] max);
    return len != 8'd0 && len <= max;
  endfunction
endpackage

// File: rtl/tpu_cmd_frontend.sv
// tpu_cmd_frontend: host register port that snapshots operand fields into commands and tracks their completion
module tpu_cmd_frontend
  import tpu_pkg::*;
#(
  parameter int ADDR_WIDTH           = CMD_AW,
  parameter int SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int CNT_WIDTH            = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_wr_en,
  input  logic        reg_rd_en,
  input  logic [3:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        reg_rvalid,
  output logic        cmd_valid,
  output logic [63:0] cmd_data,
  input  logic        cmd_ready,
  input  logic        core_busy,
  input  logic        done_irq,
  output logic        irq,
  output logic        idle
);
  if (4*ADDR_WIDTH+24 != 64 || ADDR_WIDTH != CMD_AW || CNT_WIDTH > 8) begin : g_bad_params
    $error("tpu_cmd_frontend: ADDR_WIDTH must fill the 64-bit command and counters must fit 8-bit status fields");
  end
  localparam logic [7:0] LEN_MAX = 8'(SYSTOLIC_ARRAY_WIDTH);
  logic [7:0]            len_m, len_k, len_n;
  logic [ADDR_WIDTH-1:0] addr_a, addr_b, addr_c, addr_d;
  logic                  irq_en, irq_pend, err_ovf, err_dim, err_spur;
  logic [CNT_WIDTH-1:0]  outstanding, completed;
  logic [31:0]           rd_mux, status;
  logic                  hs, doorbell, dims_ok, clr_pend, clr_err, unused_wdata;
  command_t              snap;
  assign hs           = cmd_valid && cmd_ready;
  assign doorbell     = reg_wr_en && reg_addr == REG_DOORBELL;
  assign dims_ok      = len_ok(len_m, LEN_MAX) && len_ok(len_k, LEN_MAX) && len_ok(len_n, LEN_MAX);
  assign clr_pend     = reg_wr_en && reg_addr == REG_CTRL && reg_wdata[8];
  assign clr_err      = reg_wr_en && reg_addr == REG_CTRL && reg_wdata[9];
  assign snap         = '{addr_d: addr_d, addr_c: addr_c, addr_b: addr_b, addr_a: addr_a,
                          len_n: len_n, len_k: len_k, len_m: len_m};
  assign irq          = irq_pend && irq_en;
  assign idle         = outstanding == '0 && !cmd_valid;
  assign unused_wdata = ^reg_wdata;
  // host-writable field and control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      {len_m, len_k, len_n} <= '0;
      {addr_a, addr_b, addr_c, addr_d} <= '0;
      irq_en <= 1'b0;
    end else if (reg_wr_en) begin
      if (reg_addr == REG_DIMS) {len_n, len_k, len_m} <= reg_wdata[23:0];
      if (reg_addr == REG_ADDR_AB) begin
        addr_a <= reg_wdata[ADDR_WIDTH-1:0];
        addr_b <= reg_wdata[16+ADDR_WIDTH-1:16];
      end
      if (reg_addr == REG_ADDR_CD) begin
        addr_c <= reg_wdata[ADDR_WIDTH-1:0];
        addr_d <= reg_wdata[16+ADDR_WIDTH-1:16];
      end
      if (reg_addr == REG_CTRL) irq_en <= reg_wdata[0];
    end
  end
  // single-entry issue slot; a doorbell may refill it in the same cycle it drains
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd_data  <= '0;
      err_dim   <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      if (doorbell && dims_ok && (!cmd_valid || hs)) begin
        cmd_valid <= 1'b1;
        cmd_data  <= pack_cmd(snap);
      end else if (hs) begin
        cmd_valid <= 1'b0;
      end
      err_dim <= (doorbell && !dims_ok) || (err_dim && !clr_err);
      err_ovf <= (doorbell && dims_ok && cmd_valid && !hs) || (err_ovf && !clr_err);
    end
  end
  // outstanding/completed tracking and completion interrupt; set wins over clear
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      completed   <= '0;
      irq_pend    <= 1'b0;
      err_spur    <= 1'b0;
    end else begin
      if (hs && !done_irq)
        outstanding <= outstanding == '1 ? outstanding : outstanding + CNT_WIDTH'(1);
      else if (done_irq && !hs)
        outstanding <= outstanding == '0 ? outstanding : outstanding - CNT_WIDTH'(1);
      completed <= completed + CNT_WIDTH'(done_irq);
      irq_pend  <= (done_irq && !hs && outstanding == CNT_WIDTH'(1)) || (irq_pend && !clr_pend);
      err_spur  <= (done_irq && !hs && outstanding == '0) || (err_spur && !clr_err);
    end
  end
  // status word assembly
  always_comb begin
    status = '0;
    status[ST_CMD_VALID] = cmd_valid;
    status[ST_CORE_BUSY] = core_busy;
    status[ST_IRQ_PEND]  = irq_pend;
    status[ST_ERR_OVF]   = err_ovf;
    status[ST_ERR_DIM]   = err_dim;
    status[ST_ERR_SPUR]  = err_spur;
    status[ST_OUTST_LSB +: CNT_WIDTH] = outstanding;
    status[ST_COMPL_LSB +: CNT_WIDTH] = completed;
  end
  // read data selection by word address
  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      REG_DIMS:    rd_mux = {8'd0, len_n, len_k, len_m};
      REG_ADDR_AB: rd_mux = {{(16-ADDR_WIDTH){1'b0}}, addr_b, {(16-ADDR_WIDTH){1'b0}}, addr_a};
      REG_ADDR_CD: rd_mux = {{(16-ADDR_WIDTH){1'b0}}, addr_d, {(16-ADDR_WIDTH){1'b0}}, addr_c};
      REG_STATUS:  rd_mux = status;
      REG_CTRL:    rd_mux = {31'd0, irq_en};
      default:     rd_mux = '0;
    endcase
  end
  // registered read port; sees pre-write values when a write hits the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_rvalid <= 1'b0;
      reg_rdata  <= '0;
    end else begin
      reg_rvalid <= reg_rd_en;
      reg_rdata  <= reg_rd_en ? rd_mux : 32'd0;
    end
  end
endmodule

// File: tb/tb_tpu_cmd_frontend.sv
// tb_tpu_cmd_frontend: table-driven register checks plus directed command/interrupt sequences
module tb_tpu_cmd_frontend;
  import tpu_pkg::*;
  logic        clk = 0, rst = 1;
  logic        reg_wr_en = 0, reg_rd_en = 0, cmd_ready = 0, core_busy = 0, done_irq = 0;
  logic [3:0]  reg_addr = 0;
  logic [31:0] reg_wdata = 0, reg_rdata;
  logic        reg_rvalid, cmd_valid, irq, idle;
  logic [63:0] cmd_data;
  int vectors = 0, miscompares = 0;
  typedef struct {bit wr; logic [3:0] addr; logic [31:0] data;} vec_t;
  vec_t vecs[17];
  tpu_cmd_frontend dut (
    .clk(clk), .rst(rst), .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid), .cmd_valid(cmd_valid),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .core_busy(core_busy), .done_irq(done_irq),
    .irq(irq), .idle(idle)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    reg_wr_en = 1; reg_addr = a; reg_wdata = d;
    step();
    reg_wr_en = 0;
  endtask
  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    reg_rd_en = 1; reg_addr = a;
    step();
    reg_rd_en = 0;
    chk({name, ".rvalid"}, 64'(reg_rvalid), 64'd1);
    chk(name, 64'(reg_rdata), 64'(exp));
  endtask
  task automatic do_reset();
    rst = 1; cmd_ready = 0; done_irq = 0; core_busy = 0;
    step();
    rst = 0;
  endtask
  task automatic pulse_done();
    done_irq = 1;
    step();
    done_irq = 0;
  endtask
  task automatic load_t1();
    wr(REG_DIMS, 32'h0010_1010);
    wr(REG_ADDR_AB, 32'h0040_0000);
    wr(REG_ADDR_CD, 32'h00C0_0080);
  endtask
  logic [63:0] d1, d_len1;
  initial begin
    d1     = {10'hC0, 10'h80, 10'h40, 10'h0, 8'h10, 8'h10, 8'h10};
    d_len1 = {10'h234, 10'h278, 10'h3FF, 10'h3FF, 8'h01, 8'h01, 8'h01};
    vecs[0]  = '{1'b1, REG_DIMS,    32'hFFFF_FFFF};
    vecs[1]  = '{1'b0, REG_DIMS,    32'h00FF_FFFF};
    vecs[2]  = '{1'b1, REG_ADDR_AB, 32'hFFFF_FFFF};
    vecs[3]  = '{1'b0, REG_ADDR_AB, 32'h03FF_03FF};
    vecs[4]  = '{1'b1, REG_ADDR_CD, 32'h1234_5678};
    vecs[5]  = '{1'b0, REG_ADDR_CD, 32'h0234_0278};
    vecs[6]  = '{1'b0, REG_DOORBELL, 32'h0};
    vecs[7]  = '{1'b1, 4'h9,        32'hDEAD_BEEF};
    vecs[8]  = '{1'b0, 4'h9,        32'h0};
    vecs[9]  = '{1'b0, 4'hF,        32'h0};
    vecs[10] = '{1'b1, REG_CTRL,    32'hFFFF_FFFF};
    vecs[11] = '{1'b0, REG_CTRL,    32'h1};
    vecs[12] = '{1'b0, REG_STATUS,  32'h0};
    vecs[13] = '{1'b1, REG_DIMS,    32'h0001_0101};
    vecs[14] = '{1'b0, REG_DIMS,    32'h0001_0101};
    vecs[15] = '{1'b1, REG_STATUS,  32'hFFFF_FFFF};
    vecs[16] = '{1'b0, REG_STATUS,  32'h0};
    step();
    step();
    rst = 0;
    chk("rst.cmd_valid", 64'(cmd_valid), 64'd0);
    chk("rst.irq", 64'(irq), 64'd0);
    chk("rst.rvalid", 64'(reg_rvalid), 64'd0);
    chk("rst.idle", 64'(idle), 64'd1);
    chk("rst.cmd_data", cmd_data, 64'd0);
    rd_chk("rst.status", REG_STATUS, 32'h0);
    // register map table
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].data);
      else rd_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data);
    end
    wr(REG_DOORBELL, 32'h0);
    chk("len1.cmd_valid", 64'(cmd_valid), 64'd1);
    chk("len1.cmd_data", cmd_data, d_len1);
    // same-cycle read and write returns old value
    reg_rd_en = 1; reg_wr_en = 1; reg_addr = REG_DIMS; reg_wdata = 32'h0003_0405;
    step();
    reg_rd_en = 0; reg_wr_en = 0;
    chk("rw.old", 64'(reg_rdata), 64'h0001_0101);
    rd_chk("rw.new", REG_DIMS, 32'h0003_0405);
    // T1 single command, ready throughout
    do_reset();
    load_t1();
    cmd_ready = 1;
    wr(REG_DOORBELL, 32'h1);
    chk("t1.valid", 64'(cmd_valid), 64'd1);
    chk("t1.data", cmd_data, d1);
    step();
    chk("t1.drop", 64'(cmd_valid), 64'd0);
    rd_chk("t1.status", REG_STATUS, 32'h0000_0100);
    // T2 back-pressure and overflow
    do_reset();
    load_t1();
    wr(REG_DOORBELL, 32'h1);
    wr(REG_DIMS, 32'h0002_0304);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("t2.hold_valid", 64'(cmd_valid), 64'd1);
      chk("t2.hold_data", cmd_data, d1);
    end
    wr(REG_DOORBELL, 32'h1);
    chk("t2.ovf_data", cmd_data, d1);
    rd_chk("t2.ovf_status", REG_STATUS, 32'h0000_0009);
    cmd_ready = 1;
    chk("t2.issue_data", cmd_data, d1);
    step();
    chk("t2.after_hs", 64'(cmd_valid), 64'd0);
    rd_chk("t2.status", REG_STATUS, 32'h0000_0108);
    // T3 dimension errors
    do_reset();
    load_t1();
    wr(REG_DIMS, 32'h0010_0010);
    wr(REG_DOORBELL, 32'h1);
    chk("t3.k0", 64'(cmd_valid), 64'd0);
    wr(REG_DIMS, 32'h0011_1010);
    wr(REG_DOORBELL, 32'h1);
    chk("t3.n17", 64'(cmd_valid), 64'd0);
    rd_chk("t3.err", REG_STATUS, 32'h0000_0010);
    wr(REG_CTRL, 32'h200);
    rd_chk("t3.clr", REG_STATUS, 32'h0);
    // T4 three commands, completions and interrupt
    do_reset();
    load_t1();
    cmd_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      wr(REG_DOORBELL, 32'h1);
      step();
      rd_chk($sformatf("t4.out%0d", i), REG_STATUS, 32'(i) << 8);
    end
    pulse_done();
    rd_chk("t4.done1", REG_STATUS, 32'h0001_0200);
    pulse_done();
    rd_chk("t4.done2", REG_STATUS, 32'h0002_0100);
    pulse_done();
    rd_chk("t4.done3", REG_STATUS, 32'h0003_0004);
    chk("t4.irq_masked", 64'(irq), 64'd0);
    wr(REG_CTRL, 32'h1);
    chk("t4.irq_on", 64'(irq), 64'd1);
    rd_chk("t4.ctrl", REG_CTRL, 32'h1);
    wr(REG_CTRL, 32'h101);
    chk("t4.irq_clr", 64'(irq), 64'd0);
    rd_chk("t4.status_clr", REG_STATUS, 32'h0003_0000);
    chk("t4.idle", 64'(idle), 64'd1);
    // T5 coincident completion/handshake, spurious completion, set-over-clear
    do_reset();
    load_t1();
    cmd_ready = 1;
    wr(REG_DOORBELL, 32'h1);
    step();
    cmd_ready = 0;
    wr(REG_DOORBELL, 32'h1);
    cmd_ready = 1;
    pulse_done();
    cmd_ready = 0;
    rd_chk("t5.coincide", REG_STATUS, 32'h0001_0100);
    pulse_done();
    pulse_done();
    core_busy = 1;
    rd_chk("t5.spur", REG_STATUS, 32'h0003_0026);
    core_busy = 0;
    wr(REG_CTRL, 32'h100);
    rd_chk("t5.pend_clr", REG_STATUS, 32'h0003_0020);
    cmd_ready = 1;
    wr(REG_DOORBELL, 32'h1);
    step();
    done_irq = 1;
    wr(REG_CTRL, 32'h100);
    done_irq = 0;
    rd_chk("t5.set_wins", REG_STATUS, 32'h0004_0024);
    // T6 reset mid-operation
    do_reset();
    load_t1();
    cmd_ready = 1;
    for (int i = 0; i < 2; i++) begin
      wr(REG_DOORBELL, 32'h1);
      step();
    end
    cmd_ready = 0;
    wr(REG_DOORBELL, 32'h1);
    chk("t6.pre_valid", 64'(cmd_valid), 64'd1);
    chk("t6.pre_idle", 64'(idle), 64'd0);
    rst = 1;
    step();
    rst = 0;
    chk("t6.valid", 64'(cmd_valid), 64'd0);
    chk("t6.idle", 64'(idle), 64'd1);
    rd_chk("t6.status", REG_STATUS, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
